// File: rtl/awgn_channel_adder.sv
// AWGN channel stage: adds lockstep I/Q noise pairs to a symbol stream
// with Q1.11 saturation, prefetching noise so no generator sample is lost.
module awgn_channel_adder #(
    parameter int DATA_WIDTH       = 12,
    parameter int NOISE_FIFO_DEPTH = 8,
    parameter int NOISE_LAT        = 3,
    parameter int SAT_CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    in_i,
    input  logic [DATA_WIDTH-1:0]    in_q,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     noise_en,
    input  logic [DATA_WIDTH-1:0]    noise_i,
    input  logic [DATA_WIDTH-1:0]    noise_q,
    input  logic                     noise_valid,
    input  logic                     bypass,
    output logic [DATA_WIDTH-1:0]    out_i,
    output logic [DATA_WIDTH-1:0]    out_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SAT_CNT_WIDTH-1:0] sat_count,
    input  logic                     sat_clear,
    output logic                     noise_ovf
);

    localparam int AW = $clog2(NOISE_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(NOISE_FIFO_DEPTH + NOISE_LAT + 1);
    localparam int BW = ((CW > IW) ? CW : IW) + 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [BW-1:0] DEPTH_B = BW'(NOISE_FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(NOISE_FIFO_DEPTH);

    logic [PW-1:0]         mem [NOISE_FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [IW-1:0]         inflight;
    logic                  armed;

    logic                  xfer;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic                  ret;
    logic [BW-1:0]         budget;
    logic [DATA_WIDTH-1:0] head_i;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH:0]   sum_i;
    logic [DATA_WIDTH:0]   sum_q;
    logic                  clip_i;
    logic                  clip_q;
    logic [DATA_WIDTH-1:0] sat_i;
    logic [DATA_WIDTH-1:0] sat_q;

    // Requests are budgeted against FIFO space, so in-flight noise always fits.
    assign budget   = BW'(fifo_count) + BW'(inflight);
    assign noise_en = armed && (budget < DEPTH_B);

    assign in_ready  = armed && (!out_valid || out_ready)
                     && (bypass || (fifo_count != '0));
    assign xfer      = in_valid && in_ready;
    assign pop       = xfer && !bypass;
    assign fifo_full = (fifo_count == DEPTH_C);
    assign fifo_wr   = noise_valid && (!fifo_full || pop);
    assign ret       = noise_valid && (inflight != '0);

    assign head_i = mem[rd_ptr][PW-1:DATA_WIDTH];
    assign head_q = mem[rd_ptr][DATA_WIDTH-1:0];

    assign sum_i  = {in_i[DATA_WIDTH-1], in_i} + {head_i[DATA_WIDTH-1], head_i};
    assign sum_q  = {in_q[DATA_WIDTH-1], in_q} + {head_q[DATA_WIDTH-1], head_q};
    assign clip_i = sum_i[DATA_WIDTH] ^ sum_i[DATA_WIDTH-1];
    assign clip_q = sum_q[DATA_WIDTH] ^ sum_q[DATA_WIDTH-1];
    assign sat_i  = clip_i ? {sum_i[DATA_WIDTH], {(DATA_WIDTH-1){~sum_i[DATA_WIDTH]}}}
                           : sum_i[DATA_WIDTH-1:0];
    assign sat_q  = clip_q ? {sum_q[DATA_WIDTH], {(DATA_WIDTH-1){~sum_q[DATA_WIDTH]}}}
                           : sum_q[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= {noise_i, noise_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
            noise_ovf  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo_wr && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!fifo_wr && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (noise_en && !ret) begin
                inflight <= inflight + 1'b1;
            end else if (!noise_en && ret) begin
                inflight <= inflight - 1'b1;
            end
            if (noise_valid && fifo_full && !pop) begin
                noise_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_i     <= bypass ? in_i : sat_i;
            out_q     <= bypass ? in_q : sat_q;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (pop && (clip_i || clip_q) && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_awgn_channel_adder.sv
// Bench for awgn_channel_adder: latency-3 noise generator model plus
// a scoreboard of expected noisy samples.
module tb_awgn_channel_adder;

    localparam int DW = 12;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_i = '0;
    logic [DW-1:0] in_q = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          noise_en;
    logic [DW-1:0] noise_i;
    logic [DW-1:0] noise_q;
    logic          noise_valid;
    logic          bypass = 1'b0;
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   sat_count;
    logic          sat_clear = 1'b0;
    logic          noise_ovf;

    always #5 clk = ~clk;

    awgn_channel_adder dut (
        .clk(clk), .rst_n(rst_n),
        .in_i(in_i), .in_q(in_q), .in_valid(in_valid), .in_ready(in_ready),
        .noise_en(noise_en), .noise_i(noise_i), .noise_q(noise_q),
        .noise_valid(noise_valid), .bypass(bypass),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
        .out_ready(out_ready), .sat_count(sat_count),
        .sat_clear(sat_clear), .noise_ovf(noise_ovf)
    );

    // Noise generator model: fixed 3-cycle enable-to-valid latency.
    logic [2:0]         gv;
    logic [2:0][DW-1:0] gi;
    logic [2:0][DW-1:0] gq;
    logic [DW-1:0]      gen_i = 12'h010;
    logic [DW-1:0]      gen_q = 12'h020;
    logic               spur = 1'b0;
    logic [DW-1:0]      spur_i = 12'h055;
    logic [DW-1:0]      spur_q = 12'h066;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gv <= '0;
            gi <= '0;
            gq <= '0;
        end else begin
            gv <= {gv[1:0], noise_en};
            gi <= {gi[1:0], gen_i};
            gq <= {gq[1:0], gen_q};
        end
    end

    assign noise_valid = gv[2] | spur;
    assign noise_i     = spur ? spur_i : gi[2];
    assign noise_q     = spur ? spur_q : gq[2];

    int    n_cmp = 0;
    int    n_bad = 0;
    int    reqs = 0;
    int    xfers = 0;
    int    msat = 0;
    pair_t mfifo[$];
    pair_t expq[$];
    pair_t p;
    pair_t h;
    bit    ci;
    bit    cq;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          output bit c);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        c = 1'b0;
        if (s > 2047) begin
            c = 1'b1;
            s = 2047;
        end else if (s < -2048) begin
            c = 1'b1;
            s = -2048;
        end
        return DW'(s);
    endfunction

    // Monitor sampled on the falling edge: predicts the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mfifo.delete();
            expq.delete();
            msat = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_out", expq.size(), 1);
                end else begin
                    p = expq.pop_front();
                    check("out_i", out_i, p.i);
                    check("out_q", out_q, p.q);
                end
            end
            if (noise_en) reqs++;
            ci = 1'b0;
            cq = 1'b0;
            if (in_valid && in_ready) begin
                xfers++;
                if (bypass) begin
                    expq.push_back({in_i, in_q});
                end else if (mfifo.size() == 0) begin
                    check("fifo_underrun", mfifo.size(), 1);
                end else begin
                    h = mfifo.pop_front();
                    p.i = sat(in_i, h.i, ci);
                    p.q = sat(in_q, h.q, cq);
                    expq.push_back(p);
                end
            end
            if (sat_clear) msat = 0;
            else if ((ci || cq) && msat != 65535) msat++;
            if (noise_valid && mfifo.size() < 8) mfifo.push_back({noise_i, noise_q});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        n = 0;
        in_i = a;
        in_q = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("send_timeout", n, 0);
        tick();
        in_valid = 1'b0;
    endtask

    int x0;
    int r0;
    int s0;
    int n;

    initial begin
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_noise_en", noise_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", {out_i, out_q}, 0);
        check("rst_sat", sat_count, 0);
        check("rst_ovf", noise_ovf, 0);

        reqs = 0;
        rst_n = 1'b1;
        #1;
        check("first_cycle_en", noise_en, 0);
        repeat (20) tick();
        check("prefill_reqs", reqs, 8);
        check("prefill_level", mfifo.size(), 8);
        check("prefill_en", noise_en, 0);
        check("prefill_ovf", noise_ovf, 0);

        in_i = 12'h100;
        in_q = 12'hF00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_valid", out_valid, 1);
        check("lat_i", out_i, 12'h110);
        check("lat_q", out_q, 12'hF20);

        send(12'h7F0, 12'h000);
        check("clamp_i", out_i, 12'h7FF);
        send(12'h000, 12'h7F0);
        check("clamp_q", out_q, 12'h7FF);
        check("sat_two", sat_count, 2);
        sat_clear = 1'b1;
        send(12'h7FF, 12'h7FF);
        sat_clear = 1'b0;
        check("sat_clear_prio", sat_count, 0);
        send(12'h7FF, 12'h7FF);
        check("sat_both_once", sat_count, 1);

        repeat (10) tick();
        out_ready = 1'b0;
        in_i = 12'h123;
        in_q = 12'h456;
        in_valid = 1'b1;
        x0 = xfers;
        repeat (5) tick();
        check("stall_xfers", xfers - x0, 1);
        check("stall_ready", in_ready, 0);
        check("stall_i", out_i, 12'h133);
        check("stall_q", out_q, 12'h476);
        check("stall_no_req", noise_en, 0);

        out_ready = 1'b1;
        x0 = xfers;
        r0 = reqs;
        for (int k = 0; k < 40; k++) begin
            in_i = 12'($urandom);
            in_q = 12'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("stream_xfers", xfers - x0, 40);
        check("stream_reqs", reqs - r0, 39);

        repeat (10) tick();
        bypass = 1'b1;
        s0 = msat;
        x0 = xfers;
        r0 = reqs;
        in_i = 12'h7FF;
        in_q = 12'h7FF;
        in_valid = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0;
        tick();
        bypass = 1'b0;
        check("byp_xfers", xfers - x0, 10);
        check("byp_sat", sat_count, s0);
        check("byp_reqs", reqs - r0, 0);
        check("byp_level", mfifo.size(), 8);

        for (int k = 0; k < 400; k++) begin
            bypass    = ($urandom_range(0, 3) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clear = ($urandom_range(0, 49) == 0);
            gen_i = 12'($urandom);
            gen_q = 12'($urandom);
            case ($urandom_range(0, 3))
                0: in_i = 12'h7FF;
                1: in_i = 12'h800;
                default: in_i = 12'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: in_q = 12'h800;
                1: in_q = 12'h7FF;
                default: in_q = 12'($urandom);
            endcase
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        bypass = 1'b0;
        sat_clear = 1'b0;
        repeat (12) tick();
        check("rand_drained", expq.size(), 0);
        check("rand_sat", sat_count, msat);
        check("rand_ovf", noise_ovf, 0);

        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("ovf_set", noise_ovf, 1);
        repeat (3) tick();
        check("ovf_sticky", noise_ovf, 1);

        in_valid = 1'b1;
        repeat (4) begin
            in_i = 12'($urandom);
            in_q = 12'($urandom);
            tick();
        end
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_out", {out_i, out_q}, 0);
        check("mrst_sat", sat_count, 0);
        check("mrst_ovf", noise_ovf, 0);
        check("mrst_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_empty", in_ready, 0);
        repeat (15) tick();
        send(12'h001, 12'h002);
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("final_drain", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
